// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a uart_tx serializer through its start/busy handshake.
// Bytes are buffered in a circular store and handed over one at a time.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   input  logic                     flush,
   input  logic                     clear_overflow,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     idle,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_SENDING
   } state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          overflow_q;
   state_t        state;
   logic [TW-1:0] to_cnt;
   logic [7:0]    tx_data_q;
   logic          tx_start_q;

   logic push;
   logic pop;
   logic drop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // full is judged on the registered count, so a write while full is dropped
   // even if a pop happens in the same cycle; flush swallows any write.
   assign pop  = (state == S_IDLE) && !empty && !tx_busy;
   assign push = wr_en && !full && !flush;
   assign drop = wr_en && full && !flush;

   assign overflow = overflow_q;
   assign idle     = (state == S_IDLE) && empty;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;

   // Byte storage; contents need no reset since pointers gate every read.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush clears everything at once.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clear_overflow) begin
         overflow_q <= 1'b0;
      end
   end

   // Handshake FSM with registered tx_start/tx_data outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         to_cnt     <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  tx_data_q  <= mem[rd_ptr];
                  tx_start_q <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               to_cnt <= '0;
               state  <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= S_SENDING;
               end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                  state <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_SENDING: begin
               if (!tx_busy) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected bytes are queued as they are written and a
// monitor pops and compares on every tx_start pulse.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned BT    = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       flush;
   logic       clear_overflow;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       idle;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   int         checks = 0;
   int         errors = 0;
   int         n_starts = 0;
   int         busy_mode = 0;   // 0: serializer model, 1: forced high, 2: forced low
   int         busy_len = 3;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .clear_overflow(clear_overflow), .full(full), .empty(empty), .count(count),
      .overflow(overflow), .idle(idle), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit keep);
      wr_en   = 1'b1;
      wr_data = d;
      if (keep) exp_q.push_back(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_start(input int lim);
      bit seen = 1'b0;
      for (int i = 0; i < lim && !seen; i++) begin
         @(negedge clk);
         if (tx_start) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_start: got no tx_start within %0d cycles expected a start", lim);
      end
   endtask

   task automatic wait_idle(input int lim);
      bit done = 1'b0;
      for (int i = 0; i < lim && !done; i++) begin
         @(negedge clk);
         if (idle && exp_q.size() == 0) done = 1'b1;
      end
      check("drain_idle", idle, 1);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Serializer model: busy rises one cycle after the start pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start && busy_mode == 0) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len - 1) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Monitor: every start must match the next expected byte.
   initial begin
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            n_starts++;
            check("start_not_back_to_back", prev, 0);
            check("busy_low_at_start", tx_busy, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: got tx_data %0h expected no start", tx_data);
            end else begin
               check("tx_data_order", tx_data, exp_q.pop_front());
            end
         end
         prev = tx_start;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      rst = 1'b1; wr_en = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
      tx_busy = 1'b0; wr_data = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_idle", idle, 1);
      check("rst_count", count, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_tx_data", tx_data, 8'h00);

      // Single byte latency
      busy_len = 3;
      tick();
      wr(8'h55, 1);
      @(negedge clk);
      check("lat_count_after_write", count, 1);
      check("lat_empty_after_write", empty, 0);
      check("lat_no_start_yet", tx_start, 0);
      @(negedge clk);
      check("lat_start_n_plus_2", tx_start, 1);
      check("lat_count_after_pop", count, 0);
      wait_idle(50);

      // Ordering with a 10-cycle serializer
      busy_len = 10;
      tick();
      for (int i = 1; i <= 5; i++) wr(8'(i), 1);
      wait_idle(200);

      // Full and overflow while the serializer is stuck busy
      busy_mode = 1;
      tx_busy = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) wr(8'(8'h10 + i), 1);
      wr(8'hEE, 0);
      @(negedge clk);
      check("full_flag", full, 1);
      check("full_count", count, DEPTH);
      check("overflow_set", overflow, 1);
      clear_overflow = 1'b1;
      wr(8'hEF, 0);
      clear_overflow = 1'b0;
      @(negedge clk);
      check("overflow_set_wins", overflow, 1);
      check("full_count_kept", count, DEPTH);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      @(negedge clk);
      check("overflow_cleared", overflow, 0);
      busy_len = 3;
      busy_mode = 0;
      tx_busy = 1'b0;
      wait_idle(400);

      // Wrap-around with a write landing in every pop cycle
      busy_mode = 1;
      tx_busy = 1'b1;
      busy_len = 2;
      tick();
      for (int i = 0; i < 4; i++) wr(8'(i * 37 + 5), 1);
      busy_mode = 0;
      tx_busy = 1'b0;
      wait_start(10);
      for (int i = 4; i < 3 * DEPTH; i++) begin
         repeat (busy_len + 1) @(posedge clk);
         #1;
         wr_en = 1'b1;
         wr_data = 8'(i * 37 + 5);
         exp_q.push_back(8'(i * 37 + 5));
         @(negedge clk);
         check("wrap_count_before_pop", count, 3);
         tick();
         wr_en = 1'b0;
         wait_start(10);
         check("wrap_count_on_wr_pop", count, 3);
      end
      wait_idle(100);

      // Busy timeout with tx_busy tied low
      busy_mode = 2;
      tx_busy = 1'b0;
      tick();
      wr(8'hA5, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("timeout_still_waiting", idle, 0);
      @(negedge clk);
      check("timeout_back_to_idle", idle, 1);
      check("timeout_count", count, 0);

      // Flush during SENDING
      busy_mode = 0;
      busy_len = 10;
      tick();
      wr(8'h31, 1);
      wr(8'h32, 0);
      wr(8'h33, 0);
      wr(8'h34, 0);
      wr(8'h35, 0);
      @(negedge clk);
      check("flush_count_before", count, 4);
      flush = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'hEE;
      tick();
      flush = 1'b0;
      wr_en = 1'b0;
      @(negedge clk);
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_overflow", overflow, 0);
      check("flush_inflight_not_idle", idle, 0);
      s0 = n_starts;
      wait_idle(50);
      repeat (10) tick();
      check("flush_no_more_starts", n_starts, s0);

      // Reset while SENDING
      tick();
      wr(8'h77, 1);
      wr(8'h78, 0);
      wr(8'h79, 0);
      tick();
      @(negedge clk);
      check("rstmid_count_before", count, 2);
      check("rstmid_not_idle", idle, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tx_busy = 1'b0;
      @(negedge clk);
      check("rstmid_count", count, 0);
      check("rstmid_empty", empty, 1);
      check("rstmid_full", full, 0);
      check("rstmid_idle", idle, 1);
      check("rstmid_tx_start", tx_start, 0);
      check("rstmid_tx_data", tx_data, 8'h00);
      check("rstmid_overflow", overflow, 0);
      repeat (15) tick();
      check("final_idle", idle, 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
